// File: rtl/fft_stream_ctrl.sv
// AXI-stream shim around the FFT core: config word, NFFT-point input framing with tlast, result unpack/sign-extend.
// Latency: input path is combinational pass-through; result path is 1 registered cycle.
// Backpressure: input stalls on core tready or while a reconfig waits at a frame boundary; results are never stalled.
module fft_stream_ctrl #(
    parameter int DW        = 16,
    parameter int NFFT_LOG2 = 9,
    parameter int SCALE_W   = 10,
    parameter int CFG_W     = 16,
    parameter int FFT_OW    = 32,
    parameter int RES_W     = 26,
    parameter int OUT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_inverse,
    input  logic [SCALE_W-1:0]     cfg_scale,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_re,
    input  logic [DW-1:0]          in_im,
    output logic [CFG_W-1:0]       s_axis_config_tdata,
    output logic                   s_axis_config_tvalid,
    input  logic                   s_axis_config_tready,
    output logic [2*DW-1:0]        s_axis_data_tdata,
    output logic                   s_axis_data_tvalid,
    input  logic                   s_axis_data_tready,
    output logic                   s_axis_data_tlast,
    input  logic [2*FFT_OW-1:0]    m_axis_data_tdata,
    input  logic                   m_axis_data_tvalid,
    input  logic                   m_axis_data_tlast,
    output logic                   m_axis_data_tready,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_re,
    output logic [OUT_W-1:0]       out_im,
    output logic [NFFT_LOG2-1:0]   out_index,
    output logic                   out_last,
    output logic                   frame_err
);
    localparam logic [NFFT_LOG2-1:0] CNT_MAX = '1;
    localparam logic [0:0] ST_CFG = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    logic [0:0]           state_q;
    logic                 alive_q;
    logic                 cfg_inv_q;
    logic [SCALE_W-1:0]   cfg_scale_q;
    logic                 pend_q;
    logic [NFFT_LOG2-1:0] in_cnt_q;
    logic [NFFT_LOG2-1:0] out_cnt_q;
    logic                 gate;
    logic                 m_hs;
    logic                 out_cnt_end;
    logic                 unused_bits;

    // Reconfig may only take effect on a frame boundary; hold off the next frame until it does.
    assign gate = (state_q == ST_RUN) && !(pend_q && (in_cnt_q == '0));

    assign s_axis_data_tvalid   = in_valid && gate;
    assign in_ready             = s_axis_data_tready && gate;
    assign s_axis_data_tdata    = {in_im, in_re};
    assign s_axis_data_tlast    = (in_cnt_q == CNT_MAX);
    assign s_axis_config_tvalid = alive_q && (state_q == ST_CFG);
    assign s_axis_config_tdata  = alive_q ? CFG_W'({cfg_scale_q, ~cfg_inv_q}) : '0;
    assign m_axis_data_tready   = alive_q;

    assign m_hs        = m_axis_data_tvalid && alive_q;
    assign out_cnt_end = (out_cnt_q == CNT_MAX);
    assign unused_bits = ^m_axis_data_tdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CFG;
            alive_q     <= 1'b0;
            cfg_inv_q   <= 1'b0;
            cfg_scale_q <= '0;
            pend_q      <= 1'b0;
            in_cnt_q    <= '0;
        end else begin
            alive_q <= 1'b1;
            case (state_q)
                ST_CFG: begin
                    if (cfg_start) begin
                        cfg_inv_q   <= cfg_inverse;
                        cfg_scale_q <= cfg_scale;
                    end else if (s_axis_config_tvalid && s_axis_config_tready) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    if (cfg_start) begin
                        cfg_inv_q   <= cfg_inverse;
                        cfg_scale_q <= cfg_scale;
                        pend_q      <= 1'b1;
                    end else if (pend_q && (in_cnt_q == '0)) begin
                        state_q <= ST_CFG;
                        pend_q  <= 1'b0;
                    end
                end
            endcase
            if (in_valid && in_ready) begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_cnt_q <= '0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= m_hs;
            if (m_hs) begin
                out_re    <= OUT_W'($signed(m_axis_data_tdata[RES_W-1:0]));
                out_im    <= OUT_W'($signed(m_axis_data_tdata[FFT_OW+RES_W-1:FFT_OW]));
                out_index <= out_cnt_q;
                out_last  <= m_axis_data_tlast;
                out_cnt_q <= (m_axis_data_tlast || out_cnt_end) ? '0 : out_cnt_q + 1'b1;
            end
            if (cfg_start) begin
                out_cnt_q <= '0;
                frame_err <= 1'b0;
            end else if (m_hs && (m_axis_data_tlast != out_cnt_end)) begin
                frame_err <= 1'b1;
            end
        end
    end
endmodule
